// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - imem request/response and decode buffer handshake bundle
interface fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_adel;
    logic        dec_ready;

    modport master (
        output inst_req, inst_addr, instr_valid, instr, instr_pc, instr_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, dec_ready
    );

    modport slave (
        input  inst_req, inst_addr, instr_valid, instr, instr_pc, instr_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, dec_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - MIPS IF stage: fetch PC, single-outstanding imem handshake, one-entry decode buffer
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    pcsel,
    input  logic [31:0]   pcexception,
    input  logic [31:0]   pcbranch,
    input  logic [31:0]   pcjr,
    input  logic [31:0]   pcjump,
    fetch_ctrl_if.master  bus
);
    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_adel_q, instr_adel_d;

    logic        redirect, exc, buf_free, can_fetch, issue, adel_load, addr_hs, data_hs;
    logic [31:0] target;

    assign redirect  = |pcsel;
    assign exc       = pcsel[3];
    assign buf_free  = !instr_valid_q || bus.dec_ready;
    assign can_fetch = !reset && state_q == S_REQ && !redirect && buf_free;
    assign issue     = can_fetch && pc_q[1:0] == 2'b00;
    assign adel_load = can_fetch && pc_q[1:0] != 2'b00;
    assign addr_hs   = issue && bus.inst_addr_ok;
    assign data_hs   = state_q == S_WAIT && bus.inst_data_ok;

    always_comb begin
        target = pcjump;
        if (pcsel[3])      target = pcexception;
        else if (pcsel[2]) target = pcbranch;
        else if (pcsel[1]) target = pcjr;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        pending_pc_d  = pending_pc_q;
        discard_d     = discard_q;
        req_pc_d      = req_pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_adel_d  = instr_adel_q;

        if (addr_hs) begin
            state_d   = S_WAIT;
            req_pc_d  = pc_q;
            pc_d      = pending_q ? pending_pc_q : pc_q + 32'd4;
            pending_d = 1'b0;
        end

        if (data_hs) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
        end

        if (instr_valid_q && bus.dec_ready)
            instr_valid_d = 1'b0;

        if (data_hs && !discard_q && !exc) begin
            instr_valid_d = 1'b1;
            instr_d       = bus.inst_rdata;
            instr_pc_d    = req_pc_q;
            instr_adel_d  = 1'b0;
        end

        // A misaligned PC is reported through the buffer and parks until redirected.
        if (adel_load) begin
            instr_valid_d = 1'b1;
            instr_d       = 32'd0;
            instr_pc_d    = pc_q;
            instr_adel_d  = 1'b1;
        end

        if (redirect) begin
            if (exc) begin
                pc_d          = pcexception;
                pending_d     = 1'b0;
                instr_valid_d = 1'b0;
                if (state_q == S_WAIT && !bus.inst_data_ok)
                    discard_d = 1'b1;
            end else if (instr_valid_q || state_q == S_WAIT) begin
                pc_d = target;
            end else begin
                // Delay slot not yet requested: fetch it first, then jump.
                pending_d    = 1'b1;
                pending_pc_d = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pending_q     <= 1'b0;
            pending_pc_q  <= 32'd0;
            discard_q     <= 1'b0;
            req_pc_q      <= 32'd0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_adel_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            pending_pc_q  <= pending_pc_d;
            discard_q     <= discard_d;
            req_pc_q      <= req_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_adel_q  <= instr_adel_d;
        end
    end

    assign bus.inst_req    = issue;
    assign bus.inst_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_adel  = instr_adel_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a sequential-fetch model
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pcsel;
    logic [31:0] pcexception, pcbranch, pcjr, pcjump;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .pcsel(pcsel),
        .pcexception(pcexception), .pcbranch(pcbranch), .pcjr(pcjr), .pcjump(pcjump),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        outstanding;
    int          wait_cnt;
    int          lat;
    logic        rand_lat, rand_ok;
    logic [31:0] out_addr;
    logic [31:0] issued[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_instr[$];
    logic        cons_adel[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: imem model drives its inputs at negedge, monitors sample 1ns later.
    task automatic step();
        logic hs;
        @(negedge clk);
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'd0;
        if (outstanding) begin
            if (wait_cnt == 0) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata   = mem_word(out_addr);
            end else begin
                wait_cnt--;
            end
        end
        bus.inst_addr_ok = rand_ok ? 1'($urandom % 2) : 1'b1;
        #1;
        hs = 1'b0;
        if (reset) begin
            check("req_in_reset", {31'd0, bus.inst_req}, 32'd0);
        end else begin
            check("one_outstanding", {31'd0, bus.inst_req && outstanding}, 32'd0);
            if (bus.instr_valid && bus.dec_ready) begin
                cons_pc.push_back(bus.instr_pc);
                cons_instr.push_back(bus.instr);
                cons_adel.push_back(bus.instr_adel);
            end
            hs = bus.inst_req && bus.inst_addr_ok;
            if (hs) issued.push_back(bus.inst_addr);
        end
        if (bus.inst_data_ok) outstanding = 1'b0;
        if (hs) begin
            outstanding = 1'b1;
            out_addr    = bus.inst_addr;
            wait_cnt    = rand_lat ? int'($urandom_range(0, 3)) : lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pcsel = 4'd0;
        bus.dec_ready = 1'b1;
        outstanding = 1'b0;
        step();
        reset = 1'b0;
        issued.delete(); cons_pc.delete(); cons_instr.delete(); cons_adel.delete();
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_adel", {31'd0, bus.instr_adel}, 32'd0);
        check("rst_addr", bus.inst_addr, RST_PC);
    endtask

    initial begin
        reset = 1'b1; pcsel = 4'd0;
        pcexception = 32'd0; pcbranch = 32'd0; pcjr = 32'd0; pcjump = 32'd0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;
        bus.dec_ready = 1'b1;
        outstanding = 1'b0; wait_cnt = 0; lat = 2; rand_lat = 1'b0; rand_ok = 1'b0; out_addr = 32'd0;

        // Sequential fetch, addr_ok immediate, data two cycles later.
        do_reset();
        steps(12);
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", issued[i], RST_PC + 32'(4 * i));
            check("seq_pc", cons_pc[i], RST_PC + 32'(4 * i));
            check("seq_instr", cons_instr[i], mem_word(RST_PC + 32'(4 * i)));
        end

        // Backpressure: full buffer blocks fetch, release refills exactly once.
        do_reset();
        bus.dec_ready = 1'b0;
        steps(6);
        check("bp_req_blocked", {31'd0, bus.inst_req}, 32'd0);
        check("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("bp_pc", bus.instr_pc, RST_PC);
        bus.dec_ready = 1'b1;
        #1;
        check("bp_req_same_cycle", {31'd0, bus.inst_req}, 32'd1);
        check("bp_req_addr", bus.inst_addr, RST_PC + 32'd4);
        step();
        bus.dec_ready = 1'b0;
        steps(6);
        check("bp_issued", 32'(issued.size()), 32'd2);
        check("bp_consumed", 32'(cons_pc.size()), 32'd1);
        check("bp_refill_pc", bus.instr_pc, RST_PC + 32'd4);
        check("bp_refill_instr", bus.instr, mem_word(RST_PC + 32'd4));

        // Branch while the delay slot is in flight.
        do_reset();
        step();
        pcsel = 4'b0100; pcbranch = 32'h8000_0100;
        step();
        pcsel = 4'd0;
        steps(4);
        check("br_slot_addr", issued[0], RST_PC);
        check("br_target_addr", issued[1], 32'h8000_0100);
        check("br_slot_pc", cons_pc[0], RST_PC);
        check("br_slot_instr", cons_instr[0], mem_word(RST_PC));

        // Jump with empty buffer in S_REQ: delay slot fetched first via pending.
        do_reset();
        pcsel = 4'b0001; pcjump = 32'h8000_0200;
        #1;
        check("jmp_no_req", {31'd0, bus.inst_req}, 32'd0);
        step();
        pcsel = 4'd0;
        steps(9);
        check("jmp_slot_addr", issued[0], RST_PC);
        check("jmp_target_addr", issued[1], 32'h8000_0200);
        check("jmp_after_target", issued[2], 32'h8000_0204);

        // Exception while waiting: stale response dropped, refetch afterwards.
        do_reset();
        lat = 3;
        step();
        pcsel = 4'b1000; pcexception = 32'hbfc0_0380;
        step();
        pcsel = 4'd0;
        steps(2);
        check("exc_stale_dropped", {31'd0, bus.instr_valid}, 32'd0);
        check("exc_no_early_req", 32'(issued.size()), 32'd1);
        step();
        check("exc_req_count", 32'(issued.size()), 32'd2);
        check("exc_req_addr", issued[1], 32'hbfc0_0380);
        steps(3);
        check("exc_fill_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("exc_fill_pc", bus.instr_pc, 32'hbfc0_0380);
        check("exc_fill_instr", bus.instr, mem_word(32'hbfc0_0380));
        check("exc_nothing_consumed_stale", 32'(cons_pc.size()), 32'd0);

        // Misaligned jr target: address-error entry, then exception resumes.
        do_reset();
        lat = 2;
        step();
        pcsel = 4'b0010; pcjr = 32'h8000_0102;
        step();
        pcsel = 4'd0;
        steps(2);
        bus.dec_ready = 1'b0;
        steps(2);
        check("adel_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("adel_flag", {31'd0, bus.instr_adel}, 32'd1);
        check("adel_pc", bus.instr_pc, 32'h8000_0102);
        check("adel_instr", bus.instr, 32'd0);
        check("adel_no_req", 32'(issued.size()), 32'd1);
        pcsel = 4'b1000; pcexception = 32'hbfc0_0380; bus.dec_ready = 1'b1;
        step();
        pcsel = 4'd0;
        check("adel_exc_clears", {31'd0, bus.instr_valid}, 32'd0);
        step();
        check("adel_resume_addr", issued[1], 32'hbfc0_0380);

        // Random latency, addr_ok and decode backpressure vs sequential stream model.
        do_reset();
        rand_lat = 1'b1; rand_ok = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.dec_ready = ($urandom % 4) != 0;
            step();
        end
        check("rand_progress", {31'd0, cons_pc.size() >= 20}, 32'd1);
        for (int i = 0; i < cons_pc.size(); i++) begin
            check("rand_pc", cons_pc[i], RST_PC + 32'(4 * i));
            check("rand_instr", cons_instr[i], mem_word(RST_PC + 32'(4 * i)));
            check("rand_adel", {31'd0, cons_adel[i]}, 32'd0);
        end
        for (int i = 0; i < issued.size(); i++)
            check("rand_addr", issued[i], RST_PC + 32'(4 * i));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the IF stage of the MIPS pipeline.
- Owns the architectural fetch PC and drives the instruction-memory request/response handshake, with at most one request outstanding.
- Applies redirects from decode and exception logic, preserving MIPS delay-slot semantics.
- Feeds decode through a one-entry valid/ready instruction buffer.

Parameters:
- RESET_PC, 32'hbfc0_0000, PC loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pcsel  in  4  redirect vector; priority [3] exception > [2] branch > [1] jr > [0] jump; 0 = no redirect
- pcexception  in  32  exception target
- pcbranch  in  32  branch target
- pcjr  in  32  jr target
- pcjump  in  32  jump target
- dec_ready  in  1  decode accepts the buffered instruction this cycle
- inst_req  out  1  imem request valid
- inst_addr  out  32  imem request address (= pc)
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  response valid
- inst_rdata  in  32  response data
- instr_valid  out  1  buffer holds an instruction
- instr  out  32  buffered instruction
- instr_pc  out  32  PC of buffered instruction
- instr_adel  out  1  buffered entry is a fetch address error

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; state = S_REQ; pending = 0; discard = 0.
  - instr_valid = 0, instr = 0, instr_pc = 0, instr_adel = 0.
  - inst_req = 0 during the reset cycle.
- States:
  - S_REQ: no request outstanding.
  - S_WAIT: address accepted, data pending.
- Issue condition: state = S_REQ, pcsel = 0, pc[1:0] = 0, and (!instr_valid or dec_ready). inst_req is driven combinationally from the issue condition; inst_addr = pc.
- Address handshake: inst_req and inst_addr_ok in the same cycle → state = S_WAIT. In that cycle pc <= pending ? pending_pc : pc + 4, and pending <= 0.
- Data handshake: S_WAIT and inst_data_ok → state = S_REQ.
  - If discard: drop the data and clear discard.
  - Otherwise: load the buffer (instr = inst_rdata, instr_pc = pc of the request, instr_valid = 1, instr_adel = 0).
  - The issue rule guarantees the buffer is free at response time.
- Buffer drain: instr_valid and dec_ready with no refill → instr_valid = 0.
- Misaligned PC: S_REQ, pc[1:0] != 0, and the buffer is free (issue condition otherwise met) → no request. Buffer loads instr = 0, instr_pc = pc, instr_adel = 1. pc holds until a redirect.
- Redirect cycle (pcsel != 0): inst_req = 0.
  - Exception (pcsel[3]):
    - pc <= pcexception.
    - Buffer cleared (instr_valid = 0).
    - pending <= 0.
    - If S_WAIT without inst_data_ok in the same cycle: discard <= 1.
    - If inst_data_ok arrives in the same cycle: the response is dropped.
  - Non-exception: the delay slot is the first instruction beyond decode.
    - If instr_valid = 1 or state = S_WAIT, the delay slot is already buffered or in flight: pc <= selected target.
    - Otherwise (the delay slot is not yet requested): pending <= 1, pending_pc <= target, pc unchanged. pc takes pending_pc on the delay slot's addr_ok.
    - A same-cycle inst_data_ok is captured normally; it is the delay slot.
- No new request is issued while discard = 1; the state remains S_WAIT until the stale response returns.
- pcsel ignored while reset = 1.

Test Plan:
- Reset, then imem with addr_ok immediate and data_ok 2 cycles later, dec_ready = 1 → addresses bfc00000, bfc00004, bfc00008; instr_pc matches; no second request while one is outstanding.
- dec_ready = 0 with buffer full → inst_req stays 0; raising dec_ready issues the next address in the same cycle, and the buffer refills exactly once.
- Branch (pcsel = 4'b0100, pcbranch = 80000100) while the delay slot is in flight → delay slot delivered; next address 80000100.
- Jump (pcsel = 4'b0001, pcjump = 80000200) while the buffer is empty in S_REQ → delay slot at pc fetched first; next address 80000200; pending cleared.
- Exception (pcsel = 4'b1000, pcexception = bfc00380) in S_WAIT → stale data_ok dropped, instr_valid stays 0; next request to bfc00380 only after the stale response.
- Jr to 80000102 → instr_adel = 1, instr_pc = 80000102, no inst_req; a subsequent exception redirect resumes fetching.
